fir_sequencer: RTL and testbench

- Controller that drives one n_tap_fir instance through its whole life: coefficient load, sample streaming, optional tail flush, stop.
- Fetches LENGTH coefficients from a synchronous-read coefficient memory and presents them on consecutive cycles after a one-cycle load pulse.
- Accepts samples from an upstream valid/ready source, forwards them with the FIR load strobe, and flags each FIR output update.

---
 rtl/fir_sequencer_if.sv | 35 +++
 rtl/fir_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_fir_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_sequencer_if.sv
// fir_sequencer_if: bus bundle between the FIR sequencer and its surroundings.
//   coeff_addr / coeff_rd_en / coeff_rd_data : synchronous-read coefficient memory
//   sample_in / sample_valid / sample_ready   : upstream valid/ready sample stream
// Modports:
//   master : sequencer side (drives the memory read, accepts samples)
//   slave  : memory / sample-source side
interface fir_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic        [ADDR_WIDTH-1:0] coeff_addr;
    logic                         coeff_rd_en;
    logic signed [DATA_WIDTH-1:0] coeff_rd_data;
    logic signed [DATA_WIDTH-1:0] sample_in;
    logic                         sample_valid;
    logic                         sample_ready;

    modport master (
        output coeff_addr,
        output coeff_rd_en,
        input  coeff_rd_data,
        input  sample_in,
        input  sample_valid,
        output sample_ready
    );

    modport slave (
        input  coeff_addr,
        input  coeff_rd_en,
        output coeff_rd_data,
        output sample_in,
        output sample_valid,
        input  sample_ready
    );
endinterface

// File: rtl/fir_sequencer.sv
// fir_sequencer: drives one n_tap_fir through coefficient load, sample
// streaming, optional zero-sample tail flush and a terminal stop.
// Ports:
//   clock, reset (async, active low)     : clocking
//   start, abort                         : control requests
//   bus (fir_sequencer_if.master)        : coefficient memory + sample stream
//   fir_load_coefficients_flag,
//   fir_coefficient_in, fir_load_data_flag,
//   fir_data_in, fir_stop_data_load_flag : filter control/data
//   fir_out_valid                        : filter output updated at preceding edge
//   sample_count                         : real samples accepted
//   busy, done                           : status
module fir_sequencer #(
    parameter int LENGTH      = 10,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_SAMPLES = 64,
    parameter int COUNT_WIDTH = 16,
    parameter int FLUSH_EN    = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          abort,
    fir_sequencer_if.master               bus,
    output logic                          fir_load_coefficients_flag,
    output logic signed [DATA_WIDTH-1:0]  fir_coefficient_in,
    output logic                          fir_load_data_flag,
    output logic signed [DATA_WIDTH-1:0]  fir_data_in,
    output logic                          fir_stop_data_load_flag,
    output logic                          fir_out_valid,
    output logic        [COUNT_WIDTH-1:0] sample_count,
    output logic                          busy,
    output logic                          done
);

    localparam int CW = (LENGTH < 2) ? 2 : $clog2(LENGTH + 1);
    localparam logic [CW-1:0]          LEN_C    = CW'(LENGTH);
    localparam logic [CW-1:0]          LEN_M1   = CW'(LENGTH - 1);
    localparam logic [COUNT_WIDTH-1:0] NUM_LAST = COUNT_WIDTH'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        COEFF_PULSE,
        COEFF_LOAD,
        STREAM,
        FLUSH,
        STOP,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     rd_en_q, rd_en_d;
    logic                     load_coef_q, load_coef_d;
    logic                     ready_q, ready_d;
    logic                     load_q, load_d;
    logic signed [DATA_WIDTH-1:0] data_q, data_d;
    logic                     stop_q, stop_d;
    logic                     outv_q, outv_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     hs;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        addr_d      = '0;
        rd_en_d     = 1'b0;
        load_coef_d = 1'b0;
        ready_d     = 1'b0;
        load_d      = 1'b0;
        data_d      = data_q;
        stop_d      = 1'b0;
        count_d     = count_q;
        outv_d      = load_q;
        hs          = bus.sample_valid & ready_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = COEFF_PULSE;
                    load_coef_d = 1'b1;
                    rd_en_d     = 1'b1;
                    pend_d      = 1'b0;
                end
            end
            COEFF_PULSE: begin
                state_d = COEFF_LOAD;
                cnt_d   = CW'(1);
                rd_en_d = (LENGTH > 1);
                addr_d  = (LENGTH > 1) ? ADDR_WIDTH'(1) : '0;
                pend_d  = abort;
            end
            COEFF_LOAD: begin
                // cnt_q is the cycle index k; the memory address for k+1 is issued now
                pend_d = pend_q | abort;
                if (cnt_q == LEN_C) begin
                    if (pend_q | abort) begin
                        state_d = STOP;
                        stop_d  = 1'b1;
                    end else begin
                        state_d = STREAM;
                        ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q < LEN_M1) begin
                        rd_en_d = 1'b1;
                        addr_d  = ADDR_WIDTH'(cnt_q) + ADDR_WIDTH'(1);
                    end
                end
            end
            STREAM: begin
                if (hs) begin
                    load_d = 1'b1;
                    data_d = bus.sample_in;
                    if (count_q != '1) begin
                        count_d = count_q + COUNT_WIDTH'(1);
                    end
                end
                // a handshake coincident with abort or the final sample is still forwarded
                if (abort) begin
                    state_d = STOP;
                    stop_d  = 1'b1;
                end else if (hs && (NUM_SAMPLES != 0) && (count_q == NUM_LAST)) begin
                    if (FLUSH_EN != 0) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        state_d = STOP;
                        stop_d  = 1'b1;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            FLUSH: begin
                if (abort) begin
                    state_d = STOP;
                    stop_d  = 1'b1;
                end else begin
                    load_d = 1'b1;
                    data_d = '0;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LEN_M1) begin
                        state_d = STOP;
                        stop_d  = 1'b1;
                    end
                end
            end
            STOP: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            load_coef_q <= 1'b0;
            ready_q     <= 1'b0;
            load_q      <= 1'b0;
            data_q      <= '0;
            stop_q      <= 1'b0;
            outv_q      <= 1'b0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            load_coef_q <= load_coef_d;
            ready_q     <= ready_d;
            load_q      <= load_d;
            data_q      <= data_d;
            stop_q      <= stop_d;
            outv_q      <= outv_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // coefficients pass straight through from memory during the load phase
    assign fir_coefficient_in         = (state_q == COEFF_LOAD) ? bus.coeff_rd_data : '0;
    assign bus.coeff_addr             = addr_q;
    assign bus.coeff_rd_en            = rd_en_q;
    assign bus.sample_ready           = ready_q;
    assign fir_load_coefficients_flag = load_coef_q;
    assign fir_load_data_flag         = load_q;
    assign fir_data_in                = data_q;
    assign fir_stop_data_load_flag    = stop_q;
    assign fir_out_valid              = outv_q;
    assign sample_count               = count_q;
    assign busy                       = busy_q;
    assign done                       = done_q;

endmodule

// File: tb/tb_fir_sequencer.sv
module tb_fir_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // DUT A: 3 samples, no flush. DUT B: 2 samples with flush.
    fir_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) ifa ();
    fir_sequencer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) ifb ();

    logic start_a, abort_a, lc_a, ld_a, st_a, ov_a, busy_a, done_a;
    logic signed [7:0] ci_a, di_a;
    logic [15:0] cnt_a;
    logic start_b, abort_b, lc_b, ld_b, st_b, ov_b, busy_b, done_b;
    logic signed [7:0] ci_b, di_b;
    logic [15:0] cnt_b;

    fir_sequencer #(.LENGTH(4), .DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_SAMPLES(3),
                    .COUNT_WIDTH(16), .FLUSH_EN(0)) dut_a (
        .clock(clk), .reset(rst_n), .start(start_a), .abort(abort_a), .bus(ifa),
        .fir_load_coefficients_flag(lc_a), .fir_coefficient_in(ci_a),
        .fir_load_data_flag(ld_a), .fir_data_in(di_a), .fir_stop_data_load_flag(st_a),
        .fir_out_valid(ov_a), .sample_count(cnt_a), .busy(busy_a), .done(done_a)
    );

    fir_sequencer #(.LENGTH(4), .DATA_WIDTH(8), .ADDR_WIDTH(10), .NUM_SAMPLES(2),
                    .COUNT_WIDTH(16), .FLUSH_EN(1)) dut_b (
        .clock(clk), .reset(rst_n), .start(start_b), .abort(abort_b), .bus(ifb),
        .fir_load_coefficients_flag(lc_b), .fir_coefficient_in(ci_b),
        .fir_load_data_flag(ld_b), .fir_data_in(di_b), .fir_stop_data_load_flag(st_b),
        .fir_out_valid(ov_b), .sample_count(cnt_b), .busy(busy_b), .done(done_b)
    );

    // coefficient memories holding {1,2,3,4}, one-cycle read latency
    always @(posedge clk) begin
        if (ifa.coeff_rd_en) ifa.coeff_rd_data <= 8'(ifa.coeff_addr) + 8'd1;
        if (ifb.coeff_rd_en) ifb.coeff_rd_data <= 8'(ifb.coeff_addr) + 8'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start_a = 0; abort_a = 0; ifa.sample_valid = 0; ifa.sample_in = '0;
        start_b = 0; abort_b = 0; ifb.sample_valid = 0; ifb.sample_in = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        tick();
        // reset state
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_ready", ifa.sample_ready, 0);
        chk("rst_addr", ifa.coeff_addr, 0);
        chk("rst_rden", ifa.coeff_rd_en, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_coef_in", ci_a, 0);
        tick();
        rst_n = 1;
        tick();

        // ---- coefficient phase on A ----
        start_a = 1;
        tick(); // cycle 0
        start_a = 0;
        chk("c0_lc", lc_a, 1);
        chk("c0_addr", ifa.coeff_addr, 0);
        chk("c0_rden", ifa.coeff_rd_en, 1);
        chk("c0_busy", busy_a, 1);
        chk("c0_coef_in", ci_a, 0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("cl_lc", lc_a, 0);
            chk("cl_coef_in", ci_a, c);
            chk("cl_ready", ifa.sample_ready, 0);
            if (c < 4) begin
                chk("cl_addr", ifa.coeff_addr, c);
                chk("cl_rden", ifa.coeff_rd_en, 1);
            end else begin
                chk("cl_rden_end", ifa.coeff_rd_en, 0);
            end
        end
        tick(); // cycle 5
        chk("c5_ready", ifa.sample_ready, 1);
        chk("c5_coef_in", ci_a, 0);

        // ---- streaming with stall on A ----
        ifa.sample_valid = 1; ifa.sample_in = 8'sd5;
        tick(); // 6
        chk("s1_load", ld_a, 1);
        chk("s1_data", di_a, 5);
        chk("s1_count", cnt_a, 1);
        chk("s1_ov", ov_a, 0);
        ifa.sample_in = -8'sd2;
        tick(); // 7
        chk("s2_load", ld_a, 1);
        chk("s2_data", di_a, -2);
        chk("s2_ov", ov_a, 1);
        chk("s2_count", cnt_a, 2);
        ifa.sample_valid = 0; ifa.sample_in = 8'sd7;
        tick(); // 8
        chk("stall1_load", ld_a, 0);
        chk("stall1_ov", ov_a, 1);
        tick(); // 9
        chk("stall2_load", ld_a, 0);
        chk("stall2_ov", ov_a, 0);
        chk("stall2_ready", ifa.sample_ready, 1);
        ifa.sample_valid = 1;
        tick(); // 10
        chk("s3_load", ld_a, 1);
        chk("s3_data", di_a, 7);
        chk("s3_count", cnt_a, 3);
        chk("s3_stop", st_a, 1);
        chk("s3_ready", ifa.sample_ready, 0);
        chk("s3_busy", busy_a, 1);
        tick(); // 11
        chk("d_load", ld_a, 0);
        chk("d_stop", st_a, 0);
        chk("d_ov", ov_a, 1);
        chk("d_done", done_a, 1);
        chk("d_busy", busy_a, 0);
        chk("d_count", cnt_a, 3);
        ifa.sample_valid = 0;
        // start ignored in DONE
        start_a = 1;
        tick();
        tick();
        start_a = 0;
        chk("dn_start_lc", lc_a, 0);
        chk("dn_start_done", done_a, 1);
        chk("dn_start_busy", busy_a, 0);
        chk("dn_ov", ov_a, 0);

        // ---- flush on B ----
        start_b = 1;
        tick(); // 0
        start_b = 0;
        repeat (5) tick(); // 5
        chk("f_ready5", ifb.sample_ready, 1);
        ifb.sample_valid = 1; ifb.sample_in = 8'sd3;
        tick(); // 6
        chk("f_r1_load", ld_b, 1);
        chk("f_r1_data", di_b, 3);
        ifb.sample_in = 8'sd4;
        tick(); // 7
        chk("f_r2_load", ld_b, 1);
        chk("f_r2_data", di_b, 4);
        chk("f_r2_ready", ifb.sample_ready, 0);
        ifb.sample_in = 8'sd99; // kept valid: must not be accepted during flush
        for (int i = 1; i <= 4; i++) begin
            tick(); // 7+i
            chk("f_z_load", ld_b, 1);
            chk("f_z_data", di_b, 0);
            chk("f_z_ready", ifb.sample_ready, 0);
            chk("f_z_count", cnt_b, 2);
            chk("f_z_ov", ov_b, 1);
            chk("f_z_stop", st_b, (i == 4) ? 1 : 0);
        end
        tick(); // 12
        chk("f_end_load", ld_b, 0);
        chk("f_end_stop", st_b, 0);
        chk("f_end_done", done_b, 1);
        chk("f_end_count", cnt_b, 2);

        // ---- abort during coefficient load on A ----
        do_reset();
        chk("ab_after_rst_done", done_a, 0);
        start_a = 1;
        ifa.sample_valid = 1; ifa.sample_in = 8'sd1;
        tick(); // 0
        start_a = 0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("ab_coef_in", ci_a, c);
            abort_a = (c == 2);
        end
        abort_a = 0;
        tick(); // 5
        chk("ab_stop5", st_a, 1);
        chk("ab_ready5", ifa.sample_ready, 0);
        chk("ab_load5", ld_a, 0);
        tick(); // 6
        chk("ab_done6", done_a, 1);
        chk("ab_load6", ld_a, 0);
        chk("ab_count", cnt_a, 0);

        // ---- abort coincident with handshake on A ----
        do_reset();
        start_a = 1;
        tick(); // 0
        start_a = 0;
        repeat (5) tick(); // 5
        ifa.sample_valid = 1; ifa.sample_in = 8'sd1;
        tick(); // 6
        chk("ah_first", di_a, 1);
        ifa.sample_in = 8'sd9; abort_a = 1;
        tick(); // 7
        abort_a = 0; ifa.sample_in = 8'sd11;
        chk("ah_load", ld_a, 1);
        chk("ah_data", di_a, 9);
        chk("ah_stop", st_a, 1);
        chk("ah_ready", ifa.sample_ready, 0);
        chk("ah_count", cnt_a, 2);
        tick(); // 8
        chk("ah_load8", ld_a, 0);
        chk("ah_done8", done_a, 1);
        chk("ah_ov8", ov_a, 1);
        chk("ah_data8", di_a, 9);
        tick(); // 9
        chk("ah_load9", ld_a, 0);
        chk("ah_count9", cnt_a, 2);

        // ---- asynchronous reset mid-stream on A ----
        do_reset();
        start_a = 1;
        tick();
        start_a = 0;
        repeat (5) tick();
        ifa.sample_valid = 1; ifa.sample_in = 8'sd6;
        tick(); // 6, in STREAM with a load active
        chk("ar_pre_load", ld_a, 1);
        chk("ar_pre_busy", busy_a, 1);
        rst_n = 0;
        #2;
        chk("ar_busy", busy_a, 0);
        chk("ar_ready", ifa.sample_ready, 0);
        chk("ar_load", ld_a, 0);
        chk("ar_data", di_a, 0);
        chk("ar_count", cnt_a, 0);
        chk("ar_ov", ov_a, 0);
        #1;
        rst_n = 1;
        ifa.sample_valid = 0;
        tick();
        chk("ar_idle_busy", busy_a, 0);
        chk("ar_idle_done", done_a, 0);
        start_a = 1;
        tick();
        start_a = 0;
        chk("ar_restart_lc", lc_a, 1);
        chk("ar_restart_busy", busy_a, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
